// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multi-cycle RISC-V core built around one shared datapath
// (PC, unified instruction/data memory port, register file, sign extender and
// ALU). It decodes the latched instruction fields and drives every datapath
// enable and mux select. Flow is FETCH -> DECODE -> per-opcode states, with
// stalls on the memory-ready handshake and a sticky trap on an illegal opcode
// or a memory access that never completes.
//
// Parameters:
//   WAIT_LIMIT   cycles to wait for mem_ready in FETCH/MEMREAD/MEMWRITE
//                before trapping (1..65535, 16-bit wait counter)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   op           instr[6:0]
//   funct3       instr[14:12]
//   funct7b5     instr[30]
//   zero         ALU zero flag
//   mem_ready    memory completes the current access this cycle
//   pc_write     PC load enable
//   adr_src      memory address select (0 = PC, 1 = ALUOut)
//   mem_write    memory write strobe
//   ir_write     instruction register / OldPC load enable
//   result_src   result mux select (00 ALUOut, 01 ReadData, 10 ALU result)
//   alu_src_a    ALU A select (00 PC, 01 OldPC, 10 RD1)
//   alu_src_b    ALU B select (00 RD2, 01 ImmExt, 10 constant 4)
//   alu_control  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   imm_src      sign-extend format select
//   reg_write    register file write enable
//   trap         sticky trap flag
//   trap_cause   00 none, 01 illegal opcode, 10 memory timeout
//   state_o      current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;
    logic        r_trap;
    logic [1:0]  r_trap_cause;

    logic        w_wait_state;
    logic        w_timeout;
    logic        w_set_trap;
    logic [1:0]  w_set_cause;

    logic        w_pc_update;
    logic        w_branch;
    logic [1:0]  w_alu_op;
    logic        w_adr_src;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic [1:0]  w_result_src;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [2:0]  w_alu_control;
    logic [1:0]  w_imm_src;

    // Only these three states wait on the memory handshake.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                          (r_state == S_MEMWRITE);

    // A ready in the limit cycle still completes the access.
    assign w_timeout = w_wait_state && !mem_ready && (r_wait_cnt >= LIMIT);

    // Next state and Moore decode of enables/selects.
    always_comb begin
        w_next       = r_state;
        w_set_trap   = 1'b0;
        w_set_cause  = 2'b00;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = 2'b00;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_adr_src    = 1'b0;
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b10;
                w_alu_op     = 2'b00;
                w_result_src = 2'b10;
                if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_set_trap  = 1'b1;
                    w_set_cause = CAUSE_TIMEOUT;
                end else if (mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_update = 1'b1;
                    w_next      = S_DECODE;
                end
            end

            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BEQ:            w_next = S_BEQ;
                    default: begin
                        w_next      = S_TRAP;
                        w_set_trap  = 1'b1;
                        w_set_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
                w_next      = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_set_trap  = 1'b1;
                    w_set_cause = CAUSE_TIMEOUT;
                end else if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end

            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end

            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_result_src = 2'b00;
                // The strobe is withheld in the timeout cycle.
                if (w_timeout) begin
                    w_next      = S_TRAP;
                    w_set_trap  = 1'b1;
                    w_set_cause = CAUSE_TIMEOUT;
                end else begin
                    w_mem_write = 1'b1;
                    if (mem_ready) begin
                        w_next = S_FETCH;
                    end
                end
            end

            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end

            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end

            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end

            // PC <= ALUOut (target from DECODE) while the ALU forms OldPC+4
            // for the link write in ALUWB.
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_update  = 1'b1;
                w_next       = S_ALUWB;
            end

            S_BEQ: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b01;
                w_result_src = 2'b00;
                w_branch     = 1'b1;
                w_next       = S_FETCH;
            end

            S_TRAP: begin
                w_next = S_TRAP;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // ALU decoder.
    always_comb begin
        w_alu_control = 3'b000;
        case (w_alu_op)
            2'b00: w_alu_control = 3'b000;
            2'b01: w_alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  w_alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alu_control = 3'b101;
                    3'b110:  w_alu_control = 3'b011;
                    3'b111:  w_alu_control = 3'b010;
                    default: w_alu_control = 3'b000;
                endcase
            end
            default: w_alu_control = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        w_imm_src = 2'b00;
        case (op)
            OP_STORE: w_imm_src = 2'b01;
            OP_BEQ:   w_imm_src = 2'b10;
            OP_JAL:   w_imm_src = 2'b11;
            default:  w_imm_src = 2'b00;
        endcase
    end

    // Reset masks every enable and select combinationally, so a reset
    // landing mid-instruction cannot produce a stray write.
    always_comb begin
        if (rst) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            imm_src     = 2'b00;
            reg_write   = 1'b0;
        end else begin
            pc_write    = w_pc_update | (w_branch & zero);
            adr_src     = w_adr_src;
            mem_write   = w_mem_write;
            ir_write    = w_ir_write;
            result_src  = w_result_src;
            alu_src_a   = w_alu_src_a;
            alu_src_b   = w_alu_src_b;
            alu_control = w_alu_control;
            imm_src     = w_imm_src;
            reg_write   = w_reg_write;
        end
    end

    // State register, wait counter and sticky trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_wait_cnt   <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, which covers entry into
            // each of the waiting states.
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_wait_state && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_set_trap) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_set_cause;
            end
        end
    end

    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller (WAIT_LIMIT overridden to 4).
// Each scenario builds a list of per-cycle steps (inputs plus the expected
// packed output vector). Inputs change on the falling edge; the expected
// vector is queued, and the DUT outputs are compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_LIMIT(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o)
    );

    // {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, alu_control, imm_src, reg_write, trap, trap_cause}
    logic [22:0] obs;
    assign obs = {state_o, pc_write, adr_src, mem_write, ir_write, result_src,
                  alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
                  trap, trap_cause};

    typedef struct packed {
        logic        rs;
        logic        rdy;
        logic        z;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [22:0] e;
    } step_t;

    logic [22:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [22:0] ev(
        input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
        input logic irw, input logic [1:0] rs, input logic [1:0] sa,
        input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] imm,
        input logic rw, input logic tr, input logic [1:0] tc);
        return {st, pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, tr, tc};
    endfunction

    // Expected vectors per state, taken from the state table.
    function automatic logic [22:0] E_FETCH(input logic r, input logic [1:0] imm);
        return ev(4'd0, r, 1'b0, 1'b0, r, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_DECODE(input logic [1:0] imm);
        return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_MEMADR(input logic [1:0] imm);
        return ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_MEMREAD(input logic [1:0] imm);
        return ev(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_MEMWB(input logic [1:0] imm);
        return ev(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_MEMWRITE(input logic mw, input logic [1:0] imm);
        return ev(4'd5, 1'b0, 1'b1, mw, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_EXECR(input logic [2:0] ac);
        return ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, ac, 2'b00, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_EXECI(input logic [2:0] ac);
        return ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, ac, 2'b00, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_ALUWB(input logic [1:0] imm);
        return ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_JAL();
        return ev(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_BEQ(input logic z);
        return ev(4'd10, z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic logic [22:0] E_TRAP(input logic [1:0] tc, input logic [1:0] imm);
        return ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b1, tc);
    endfunction

    function automatic step_t mk(input logic rs, input logic rdy, input logic z,
                                 input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic [22:0] e);
        step_t s;
        s.rs = rs; s.rdy = rdy; s.z = z; s.op = o; s.f3 = f3; s.f7 = f7; s.e = e;
        return s;
    endfunction

    // Called just after a falling edge; returns on the next falling edge
    // with the FSM in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [22:0] e;
        rst = 1'b1;
        @(negedge clk);
        // Enables and selects masked while rst is high, even with ready=1.
        s.push_back(mk(1'b1, 1'b1, 1'b1, OP_JAL, 3'b000, 1'b0, 23'd0));
        s.push_back(mk(1'b0, 1'b1, 1'b1, OP_JAL, 3'b000, 1'b0, E_FETCH(1'b1, 2'b11)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_LW, 3'b010, 1'b0, E_FETCH(1'b1, 2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_DECODE(2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMADR(2'b00)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMREAD(2'b00)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMWB(2'b00)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_LW, 3'b010, 1'b0, E_FETCH(1'b1, 2'b00)));
        // Second load: ready arrives exactly in the limit cycle of MEMREAD.
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_DECODE(2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMADR(2'b00)));
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMREAD(2'b00)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMREAD(2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_MEMWB(2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_FETCH(1'b0, 2'b00)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store();
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_DECODE(2'b01)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMADR(2'b01)));
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMWRITE(1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMWRITE(1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b0, 2'b01)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b1, 2'b01)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL store step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu();
        step_t s[$];
        logic [22:0] e;
        // {op, funct3, funct7b5, expected alu_control}
        logic [6:0] t_op [9] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_I};
        logic [2:0] t_f3 [9] = '{3'b000, 3'b110, 3'b111, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b110};
        logic       t_f7 [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] t_ac [9] = '{3'b001, 3'b011, 3'b010, 3'b101, 3'b000, 3'b000, 3'b000, 3'b101, 3'b011};
        // zero held high: it must only matter in BEQ.
        for (int k = 0; k < 9; k++) begin
            s.push_back(mk(1'b0, 1'b1, 1'b1, t_op[k], t_f3[k], t_f7[k], E_FETCH(1'b1, 2'b00)));
            s.push_back(mk(1'b0, 1'b0, 1'b1, t_op[k], t_f3[k], t_f7[k], E_DECODE(2'b00)));
            if (t_op[k] == OP_R)
                s.push_back(mk(1'b0, 1'b0, 1'b1, t_op[k], t_f3[k], t_f7[k], E_EXECR(t_ac[k])));
            else
                s.push_back(mk(1'b0, 1'b0, 1'b1, t_op[k], t_f3[k], t_f7[k], E_EXECI(t_ac[k])));
            s.push_back(mk(1'b0, 1'b0, 1'b1, t_op[k], t_f3[k], t_f7[k], E_ALUWB(2'b00)));
        end
        s.push_back(mk(1'b0, 1'b0, 1'b1, OP_R, 3'b000, 1'b0, E_FETCH(1'b0, 2'b00)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL alu step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        logic [22:0] e;
        // beq taken, beq not taken, then jal, back to back.
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_BEQ, 3'b000, 1'b0, E_FETCH(1'b1, 2'b10)));
        s.push_back(mk(1'b0, 1'b0, 1'b1, OP_BEQ, 3'b000, 1'b0, E_DECODE(2'b10)));
        s.push_back(mk(1'b0, 1'b0, 1'b1, OP_BEQ, 3'b000, 1'b0, E_BEQ(1'b1)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_BEQ, 3'b000, 1'b0, E_FETCH(1'b1, 2'b10)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_BEQ, 3'b000, 1'b0, E_DECODE(2'b10)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_BEQ, 3'b000, 1'b0, E_BEQ(1'b0)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_JAL, 3'b000, 1'b0, E_FETCH(1'b1, 2'b11)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_JAL, 3'b000, 1'b0, E_DECODE(2'b11)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_JAL, 3'b000, 1'b0, E_JAL()));
        s.push_back(mk(1'b0, 1'b0, 1'b1, OP_JAL, 3'b000, 1'b0, E_ALUWB(2'b11)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_JAL, 3'b000, 1'b0, E_FETCH(1'b0, 2'b11)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL branch step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_BAD, 3'b000, 1'b0, E_FETCH(1'b1, 2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_BAD, 3'b000, 1'b0, E_DECODE(2'b00)));
        for (int k = 0; k < 10; k++)
            s.push_back(mk(1'b0, 1'(k % 2), 1'b1, OP_BAD, 3'b000, 1'b0, E_TRAP(2'b01, 2'b00)));
        // Reset cycle: enables masked, sticky trap still visible until the edge.
        s.push_back(mk(1'b1, 1'b0, 1'b0, OP_BAD, 3'b000, 1'b0,
                       ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_BAD, 3'b000, 1'b0, E_FETCH(1'b0, 2'b00)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL illegal step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        logic [22:0] e;
        // FETCH stuck: counter 0..4, trap on the fifth cycle's edge.
        for (int k = 0; k < 5; k++)
            s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_FETCH(1'b0, 2'b00)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_LW, 3'b010, 1'b0, E_TRAP(2'b10, 2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_LW, 3'b010, 1'b0, E_TRAP(2'b10, 2'b00)));
        s.push_back(mk(1'b1, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0,
                       ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 2'b10)));
        // FETCH: ready in the limit cycle wins.
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b0, 2'b01)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_DECODE(2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMADR(2'b01)));
        // MEMWRITE stuck: strobe for 4 cycles, none in the limit cycle.
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMWRITE(1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMWRITE(1'b0, 2'b01)));
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_TRAP(2'b10, 2'b01)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        logic [22:0] e;
        s.push_back(mk(1'b0, 1'b1, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b1, 2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_DECODE(2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMADR(2'b01)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_MEMWRITE(1'b1, 2'b01)));
        s.push_back(mk(1'b1, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, ev(4'd5, 1'b0, 1'b0, 1'b0, 1'b0,
                       2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00)));
        s.push_back(mk(1'b0, 1'b0, 1'b0, OP_SW, 3'b010, 1'b0, E_FETCH(1'b0, 2'b01)));
        foreach (s[i]) begin
            rst = s[i].rs; mem_ready = s[i].rdy; zero = s[i].z;
            op = s[i].op; funct3 = s[i].f3; funct7b5 = s[i].f7;
            exp_q.push_back(s[i].e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        do_reset(); test_load();
        do_reset(); test_store();
        do_reset(); test_alu();
        do_reset(); test_branch();
        do_reset(); test_illegal();
        do_reset(); test_timeout();
        do_reset(); test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
